mux4_arbiter: RTL



---
 rtl/mux4_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter driving a shared 4:1 mux select with bounded owner tenure.
// Optional ARB_LOCK_EN adds a lock input that suspends forced rotation.
module mux4_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
`ifdef ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic [3:0]       grant,
    output logic [1:0]       sel,
    output logic             active,
    output logic [CNT_W-1:0] hold_cnt
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

    logic [0:0]       state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             active_q;

    logic [1:0] c1, c2, c3, win_idx;
    logic [3:0] others;
    logic       own_req, at_limit, take, lock_w;

`ifdef ARB_LOCK_EN
    assign lock_w = lock;
`else
    assign lock_w = 1'b0;
`endif

    // Scan last+1, last+2, last+3, then last itself; owner is always tried last.
    always_comb begin
        c1 = last_q + 2'd1;
        c2 = last_q + 2'd2;
        c3 = last_q + 2'd3;
        if (req[c1])      win_idx = c1;
        else if (req[c2]) win_idx = c2;
        else if (req[c3]) win_idx = c3;
        else              win_idx = last_q;
    end

    assign others   = req & ~grant_q;
    assign own_req  = |(req & grant_q);
    assign at_limit = (hold_q == HOLD_LIM);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        hold_d  = hold_q;
        take    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) take = 1'b1;
            end
            BUSY: begin
                if (!own_req) begin
                    if (|others) begin
                        take = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = 4'b0000;
                        hold_d  = '0;
                    end
                end else if ((|others) && at_limit && !lock_w) begin
                    take = 1'b1;
                end else if (!at_limit) begin
                    hold_d = hold_q + 1'b1;
                end
            end
        endcase
        if (take) begin
            state_d = BUSY;
            grant_d = 4'b0001 << win_idx;
            sel_d   = win_idx;
            last_d  = win_idx;
            hold_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= 4'b0000;
            sel_q    <= 2'b00;
            last_q   <= 2'd3;
            hold_q   <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
            active_q <= |grant_d;
        end
    end

    assign grant    = grant_q;
    assign sel      = sel_q;
    assign active   = active_q;
    assign hold_cnt = hold_q;

endmodule
